// File: rtl/alu_nibble_sequencer.sv
// alu_nibble_sequencer: runs a WIDTH-bit ALU operation through one external
// 4-bit combinational slice, one nibble per cycle, LSB nibble first. The
// carry between nibbles is held in a register; logic mode kills the carry.
module alu_nibble_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    // request channel
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_cin,
    input  logic [3:0]       req_s,
    input  logic             req_m,
    // response channel
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_f,
    output logic             rsp_cout,
    output logic             rsp_zero,
    // 4-bit slice interface
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic             alu_cin,
    output logic [3:0]       alu_s,
    output logic             alu_m,
    input  logic [3:0]       alu_f,
    input  logic             alu_cout
);

    localparam int NIBBLES = WIDTH / 4;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       s_q, s_d;
    logic             m_q, m_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    // One-hot decode of the current nibble index.
    logic [NIBBLES-1:0] nib_hit;
    genvar gi;
    generate
        for (gi = 0; gi < NIBBLES; gi++) begin : g_nib_hit
            assign nib_hit[gi] = (idx_q == IDX_W'(gi));
        end
    endgenerate

    // Select the operand nibbles addressed by the current index.
    logic [3:0] a_nib, b_nib;
    always_comb begin
        a_nib = 4'h0;
        b_nib = 4'h0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (nib_hit[i]) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    // Next-state, datapath updates and handshake/slice outputs.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        s_d       = s_q;
        m_d       = m_q;
        carry_d   = carry_q;
        result_d  = result_q;
        zero_d    = zero_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = 4'h0;
        alu_b     = 4'h0;
        alu_cin   = 1'b0;
        alu_s     = 4'h0;
        alu_m     = 1'b0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    s_d     = req_s;
                    m_d     = req_m;
                    carry_d = req_cin & ~req_m;
                    idx_d   = '0;
                    zero_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                alu_a   = a_nib;
                alu_b   = b_nib;
                alu_s   = s_q;
                alu_m   = m_q;
                alu_cin = carry_q & ~m_q;
                for (int i = 0; i < NIBBLES; i++) begin
                    if (nib_hit[i]) begin
                        result_d[4*i +: 4] = alu_f;
                    end
                end
                carry_d = alu_cout & ~m_q;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    zero_d  = (result_d == '0);
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= 4'h0;
            m_q      <= 1'b0;
            carry_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s_q      <= s_d;
            m_q      <= m_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    // Response fields come straight from registers so they hold steady in DONE.
    assign rsp_f    = result_q;
    assign rsp_cout = carry_q;
    assign rsp_zero = zero_q;

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Testbench for alu_nibble_sequencer with a behavioural 4-bit slice and a
// full-width reference model of the same operations.
module tb_alu_nibble_sequencer;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             req_cin;
    logic [3:0]       req_s;
    logic             req_m;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_f;
    logic             rsp_cout;
    logic             rsp_zero;
    logic [3:0]       alu_a;
    logic [3:0]       alu_b;
    logic             alu_cin;
    logic [3:0]       alu_s;
    logic             alu_m;
    logic [3:0]       alu_f;
    logic             alu_cout;

    int checks = 0;
    int errors = 0;

    alu_nibble_sequencer #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_s     (req_s),
        .req_m     (req_m),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_f     (rsp_f),
        .rsp_cout  (rsp_cout),
        .rsp_zero  (rsp_zero),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_s     (alu_s),
        .alu_m     (alu_m),
        .alu_f     (alu_f),
        .alu_cout  (alu_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 4-bit slice. In logic mode it asserts cout on purpose so
    // that any leak of slice carry into the sequencer shows up.
    logic [4:0] slice_sum;
    always_comb begin
        slice_sum = 5'd0;
        alu_f     = 4'h0;
        alu_cout  = 1'b0;
        if (alu_m) begin
            case (alu_s)
                4'b0110: alu_f = alu_a ^ alu_b;
                4'b1011: alu_f = alu_a & alu_b;
                4'b1110: alu_f = alu_a | alu_b;
                4'b0000: alu_f = ~alu_a;
                default: alu_f = alu_a;
            endcase
            alu_cout = 1'b1;
        end else begin
            case (alu_s)
                4'b1001: slice_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
                4'b0110: slice_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, alu_cin};
                default: slice_sum = {1'b0, alu_a} + {4'b0, alu_cin};
            endcase
            alu_f    = slice_sum[3:0];
            alu_cout = slice_sum[4];
        end
    end

    // Whole-word reference: {cout, f}.
    function automatic logic [WIDTH:0] ref_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                              input logic cin, input logic [3:0] s, input logic m);
        logic [WIDTH:0] r;
        logic [WIDTH:0] c;
        c = {{WIDTH{1'b0}}, cin};
        if (m) begin
            case (s)
                4'b0110: r = {1'b0, a ^ b};
                4'b1011: r = {1'b0, a & b};
                4'b1110: r = {1'b0, a | b};
                4'b0000: r = {1'b0, ~a};
                default: r = {1'b0, a};
            endcase
        end else begin
            case (s)
                4'b1001: r = {1'b0, a} + {1'b0, b} + c;
                4'b0110: r = {1'b0, a} + {1'b0, ~b} + c;
                default: r = {1'b0, a} + c;
            endcase
        end
        return r;
    endfunction

    // Present a request, wait for accept, then step until rsp_valid.
    // lat = edges after the accept edge; cins = alu_cin per RUN cycle.
    task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                           input logic [3:0] s, input logic m, output int lat, output logic [3:0] cins);
        int wait_cnt;
        req_a = a; req_b = b; req_cin = cin; req_s = s; req_m = m;
        req_valid = 1'b1;
        cins = 4'h0;
        wait_cnt = 0;
        while (!req_ready && wait_cnt < 20) begin
            @(posedge clk); #1;
            wait_cnt++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            if (lat < 4) cins[lat] = alu_cin;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_rsp();
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b, required 1 0", req_ready, rsp_valid);
        end
        checks++;
        if (rsp_f !== 16'h0 || rsp_cout !== 1'b0 || rsp_zero !== 1'b0) begin
            errors++; $display("FAIL reset_rsp: f=%h cout=%b zero=%b, required 0000 0 0", rsp_f, rsp_cout, rsp_zero);
        end
        checks++;
        if ({alu_a, alu_b, alu_cin, alu_s, alu_m} !== 14'h0) begin
            errors++; $display("FAIL reset_alu: a=%h b=%h cin=%b s=%h m=%b, required all 0", alu_a, alu_b, alu_cin, alu_s, alu_m);
        end
    endtask

    task automatic test_add();
        int lat; logic [3:0] cins;
        run_txn(16'h1234, 16'h0FFF, 1'b0, 4'b1001, 1'b0, lat, cins);
        $display("txn add a=1234 b=0fff f=%h cout=%b zero=%b lat=%0d", rsp_f, rsp_cout, rsp_zero, lat);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL add_latency: got %0d, required 4", lat); end
        checks++;
        if (rsp_f !== 16'h2233 || rsp_cout !== 1'b0 || rsp_zero !== 1'b0) begin
            errors++; $display("FAIL add_result: f=%h cout=%b zero=%b, required 2233 0 0", rsp_f, rsp_cout, rsp_zero);
        end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] f0; logic c0; logic z0; int bad;
        f0 = rsp_f; c0 = rsp_cout; z0 = rsp_zero; bad = 0;
        req_a = 16'h5555; req_b = 16'h3333; req_cin = 1'b1; req_s = 4'b1001; req_m = 1'b0;
        req_valid = 1'b1; rsp_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rsp_f !== 16'h2233 || rsp_cout !== 1'b0 || rsp_zero !== z0 || rsp_valid !== 1'b1 || req_ready !== 1'b0) bad++;
        end
        $display("txn backpressure held f=%h cout=%b (entry f=%h cout=%b)", rsp_f, rsp_cout, f0, c0);
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL backpressure_hold: %0d unstable cycles, required 0", bad); end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL backpressure_release: req_ready=%b rsp_valid=%b, required 1 0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_ripple();
        int lat; logic [3:0] cins;
        run_txn(16'hFFFF, 16'h0001, 1'b0, 4'b1001, 1'b0, lat, cins);
        $display("txn ripple a=ffff b=0001 f=%h cout=%b zero=%b cins=%b", rsp_f, rsp_cout, rsp_zero, cins);
        checks++;
        if (rsp_f !== 16'h0000 || rsp_cout !== 1'b1 || rsp_zero !== 1'b1) begin
            errors++; $display("FAIL ripple_result: f=%h cout=%b zero=%b, required 0000 1 1", rsp_f, rsp_cout, rsp_zero);
        end
        checks++;
        if (cins !== 4'b1110) begin errors++; $display("FAIL ripple_cin: nibble3..0 %b, required 1110", cins); end
        release_rsp();
    endtask

    task automatic test_logic();
        int lat; logic [3:0] cins;
        run_txn(16'hA5A5, 16'hFFFF, 1'b1, 4'b0110, 1'b1, lat, cins);
        $display("txn xor a=a5a5 b=ffff f=%h cout=%b cins=%b", rsp_f, rsp_cout, cins);
        checks++;
        if (rsp_f !== 16'h5A5A || rsp_cout !== 1'b0 || rsp_zero !== 1'b0) begin
            errors++; $display("FAIL logic_result: f=%h cout=%b zero=%b, required 5a5a 0 0", rsp_f, rsp_cout, rsp_zero);
        end
        checks++;
        if (cins !== 4'b0000) begin errors++; $display("FAIL logic_cin: nibble3..0 %b, required 0000", cins); end
        release_rsp();
        checks++;
        if ({alu_a, alu_b, alu_cin, alu_s, alu_m} !== 14'h0) begin
            errors++; $display("FAIL idle_alu: a=%h b=%h s=%h m=%b, required all 0", alu_a, alu_b, alu_s, alu_m);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat; logic [3:0] cins;
        req_a = 16'h9876; req_b = 16'h1111; req_cin = 1'b0; req_s = 4'b1001; req_m = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (alu_a !== 4'h8 || alu_b !== 4'h1) begin
            errors++; $display("FAIL midrun_idx2: alu_a=%h alu_b=%h, required 8 1", alu_a, alu_b);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_f !== 16'h0 || rsp_cout !== 1'b0 || rsp_zero !== 1'b0) begin
            errors++; $display("FAIL midrun_reset_rsp: ready=%b valid=%b f=%h cout=%b zero=%b, required 1 0 0000 0 0",
                               req_ready, rsp_valid, rsp_f, rsp_cout, rsp_zero);
        end
        checks++;
        if ({alu_a, alu_b, alu_cin, alu_s, alu_m} !== 14'h0) begin
            errors++; $display("FAIL midrun_reset_alu: a=%h b=%h cin=%b s=%h m=%b, required all 0", alu_a, alu_b, alu_cin, alu_s, alu_m);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_txn(16'h0001, 16'h0001, 1'b1, 4'b1001, 1'b0, lat, cins);
        $display("txn after_reset a=0001 b=0001 cin=1 f=%h cout=%b", rsp_f, rsp_cout);
        checks++;
        if (rsp_f !== 16'h0003 || rsp_cout !== 1'b0 || lat !== 4) begin
            errors++; $display("FAIL after_reset_add: f=%h cout=%b lat=%0d, required 0003 0 4", rsp_f, rsp_cout, lat);
        end
        release_rsp();
    endtask

    task automatic test_random();
        logic [3:0] codes_s [7];
        logic       codes_m [7];
        int lat; logic [3:0] cins; int bad; int pick; int hold;
        logic [WIDTH-1:0] a, b; logic cin; logic [WIDTH:0] exp;
        codes_s = '{4'b1001, 4'b0110, 4'b0000, 4'b0110, 4'b1011, 4'b1110, 4'b0000};
        codes_m = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        bad = 0;
        for (int n = 0; n < 24; n++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
            if (n == 5) begin a = 16'h8000; b = 16'h8000; end
            pick = int'($urandom_range(0, 6));
            exp = ref_op(a, b, cin, codes_s[pick], codes_m[pick]);
            run_txn(a, b, cin, codes_s[pick], codes_m[pick], lat, cins);
            $display("txn rand a=%h b=%h cin=%b s=%b m=%b f=%h cout=%b exp=%h/%b",
                     a, b, cin, codes_s[pick], codes_m[pick], rsp_f, rsp_cout, exp[WIDTH-1:0], exp[WIDTH]);
            checks++;
            if (rsp_f !== exp[WIDTH-1:0] || rsp_cout !== exp[WIDTH] || rsp_zero !== (exp[WIDTH-1:0] == '0) || lat !== 4) begin
                errors++; bad++;
                $display("FAIL rand_%0d: f=%h cout=%b zero=%b lat=%0d, required %h %b %b 4",
                         n, rsp_f, rsp_cout, rsp_zero, lat, exp[WIDTH-1:0], exp[WIDTH], (exp[WIDTH-1:0] == '0));
            end
            hold = int'($urandom_range(0, 3));
            for (int h = 0; h < hold; h++) begin @(posedge clk); #1; end
            release_rsp();
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] ta [3];
        logic [WIDTH-1:0] tb [3];
        logic             tc [3];
        logic [WIDTH:0]   exp;
        int sent, got, last, cyc; logic pending;
        for (int i = 0; i < 3; i++) begin
            ta[i] = WIDTH'($urandom); tb[i] = WIDTH'($urandom); tc[i] = 1'($urandom);
        end
        req_a = ta[0]; req_b = tb[0]; req_cin = tc[0]; req_s = 4'b1001; req_m = 1'b0;
        req_valid = 1'b1; rsp_ready = 1'b1;
        sent = 0; got = 0; last = 0; cyc = 0;
        while (got < 3 && cyc < 60) begin
            pending = 1'b0;
            if (rsp_valid) begin
                exp = ref_op(ta[got], tb[got], tc[got], 4'b1001, 1'b0);
                $display("txn b2b #%0d f=%h cout=%b exp=%h/%b cycle=%0d", got, rsp_f, rsp_cout, exp[WIDTH-1:0], exp[WIDTH], cyc);
                checks++;
                if (rsp_f !== exp[WIDTH-1:0] || rsp_cout !== exp[WIDTH]) begin
                    errors++; $display("FAIL b2b_result_%0d: f=%h cout=%b, required %h %b", got, rsp_f, rsp_cout, exp[WIDTH-1:0], exp[WIDTH]);
                end
                if (got > 0) begin
                    checks++;
                    if (cyc - last !== 6) begin
                        errors++; $display("FAIL b2b_spacing_%0d: %0d cycles, required 6", got, cyc - last);
                    end
                end
                last = cyc;
                got++;
            end
            if (req_ready && req_valid) begin
                pending = 1'b1;
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (pending) begin
                if (sent < 3) begin
                    req_a = ta[sent]; req_b = tb[sent]; req_cin = tc[sent];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        checks++;
        if (got !== 3) begin errors++; $display("FAIL b2b_count: %0d responses, required 3", got); end
        req_valid = 1'b0; rsp_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_cin = 1'b0; req_s = 4'h0; req_m = 1'b0;
        @(posedge clk); #1;
        test_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        test_add();
        test_backpressure();
        test_ripple();
        test_logic();
        test_reset_mid_run();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
